// File: rtl/sha_msg_sched.sv
// SHA-256 message-schedule expander: loads 16 message words, then emits W[0..63] with round index.
// Optional build macro SHA_KROM_EN adds the K[t] round-constant ROM on ckey; otherwise ckey is 0.
module sha_msg_sched #(
  parameter int unsigned NROUNDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] win,
  input  logic        win_valid,
  output logic        win_ready,
  output logic [31:0] warray,
  output logic [31:0] ckey,
  output logic [5:0]  wround,
  output logic        wvalid,
  input  logic        wready,
  output logic        wlast
);

  localparam int unsigned WW = 32;
  localparam int unsigned TW = 6;
  localparam int unsigned NW = 16;

  typedef enum logic {LOAD, EMIT} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              ld_cnt_q, ld_cnt_d;
  logic [TW-1:0]           t_q, t_d;
  logic [NW-1:0][WW-1:0]   win16_q, win16_d;
  logic [WW-1:0]           w_new;

  function automatic logic [WW-1:0] sig0(input logic [WW-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [WW-1:0] sig1(input logic [WW-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

`ifdef SHA_KROM_EN
  localparam logic [WW-1:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  // Gated to zero outside EMIT so ckey reads 0 in reset and while loading.
  assign ckey = (state_q == EMIT) ? K_ROM[t_q] : '0;
`else
  assign ckey = '0;
`endif

  assign win_ready = rst & (state_q == LOAD);
  assign wvalid    = (state_q == EMIT);
  assign warray    = win16_q[0];
  assign wround    = t_q;
  assign wlast     = (state_q == EMIT) && (t_q == TW'(NROUNDS - 1));

  // Next schedule word W[t+16]; words produced for t>=48 simply fall off the window.
  assign w_new = sig1(win16_q[14]) + win16_q[9] + sig0(win16_q[1]) + win16_q[0];

  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    t_d      = t_q;
    win16_d  = win16_q;
    case (state_q)
      LOAD: begin
        if (win_valid && win_ready) begin
          win16_d  = {win, win16_q[NW-1:1]};
          ld_cnt_d = ld_cnt_q + 4'd1;
          if (ld_cnt_q == 4'd15) state_d = EMIT;
        end
      end
      EMIT: begin
        if (wready) begin
          win16_d = {w_new, win16_q[NW-1:1]};
          t_d     = t_q + TW'(1);
          if (t_q == TW'(NROUNDS - 1)) begin
            t_d     = '0;
            state_d = LOAD;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= LOAD;
      ld_cnt_q <= '0;
      t_q      <= '0;
      win16_q  <= '0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      t_q      <= t_d;
      win16_q  <= win16_d;
    end
  end

endmodule
